// File: rtl/syn_sys_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : syn_sys_mem_arb                                                 |
// | Description: Two-client round-robin arbiter in front of the system memory   |
// |              controller port. Client 0 is the PCM capture writer, client 1  |
// |              is the HDMI frame reader. Requests are serialised into one     |
// |              command stream. Read data returns to the issuing client using  |
// |              an in-order tag FIFO.                                          |
// | Ports      : clk, rst_n (async, active low)                                 |
// |              cN_wren/cN_rden/cN_addr/cN_wdata -> cN_wait                    |
// |              cN_rd_valid/cN_rdata  read return to client N                  |
// |              mem_wren/mem_rden/mem_addr/mem_wdata <- mem_wait                |
// |              mem_rd_valid/mem_rdata read return from controller             |
// |              rd_err  sticky: return seen with no outstanding read           |
// | Config     : SYN_SYS_MEM_ARB_STATS_EN adds c0_grant_cnt / c1_grant_cnt      |
// | Revision   : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module syn_sys_mem_arb #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 27,
   parameter int RD_FIFO_DEPTH = 8,
   parameter int STATS_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c0_wren,
   input  logic              c0_rden,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_wait,
   output logic              c0_rd_valid,
   output logic [DATA_W-1:0] c0_rdata,
   input  logic              c1_wren,
   input  logic              c1_rden,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_wait,
   output logic              c1_rd_valid,
   output logic [DATA_W-1:0] c1_rdata,
   input  logic              mem_wait,
   output logic              mem_wren,
   output logic              mem_rden,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rd_err
`ifdef SYN_SYS_MEM_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] c0_grant_cnt,
   output logic [STATS_W-1:0] c1_grant_cnt
`endif
);

   localparam int             PTR_W   = $clog2(RD_FIFO_DEPTH);
   localparam logic [PTR_W:0] c_depth = RD_FIFO_DEPTH[PTR_W:0];

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   if (RD_FIFO_DEPTH < 2 || (RD_FIFO_DEPTH & (RD_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RD_FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (STATS_W < 1) begin : g_bad_stats_w
      $error("STATS_W must be at least 1");
   end

   logic [0:0]               r_state;
   logic                     r_rr_ptr;
   logic                     r_winner;
   logic [RD_FIFO_DEPTH-1:0] r_tag_mem;
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [PTR_W-1:0]         r_rd_ptr;
   logic [PTR_W:0]           r_count;

   logic w_full, w_empty, w_elig0, w_elig1, w_pick;
   logic w_accept, w_push, w_pop, w_head;

   assign w_full  = (r_count == c_depth);
   assign w_empty = (r_count == '0);

   // A read may only start if its tag is guaranteed a FIFO slot.
   assign w_elig0 = c0_wren | (c0_rden & ~w_full);
   assign w_elig1 = c1_wren | (c1_rden & ~w_full);

   // Client rr_ptr wins if eligible, otherwise the other one.
   assign w_pick  = r_rr_ptr ? w_elig1 : ~w_elig0;

   assign w_accept = (r_state == S_ISSUE) & ~mem_wait;
   assign w_push   = w_accept & mem_rden;
   assign w_pop    = mem_rd_valid & ~w_empty;
   assign w_head   = r_tag_mem[r_rd_ptr];

   // Acceptance is reported combinationally so the client can drop its request
   // in the same cycle the controller takes the command.
   assign c0_wait = ~(w_accept & ~r_winner);
   assign c1_wait = ~(w_accept &  r_winner);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= 1'b0;
         r_winner  <= 1'b0;
         mem_wren  <= 1'b0;
         mem_rden  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_elig0 | w_elig1) begin
                  r_winner  <= w_pick;
                  // Write wins over a simultaneous read from the same client.
                  mem_wren  <= w_pick ? c1_wren : c0_wren;
                  mem_rden  <= w_pick ? (~c1_wren & c1_rden) : (~c0_wren & c0_rden);
                  mem_addr  <= w_pick ? c1_addr  : c0_addr;
                  mem_wdata <= w_pick ? c1_wdata : c0_wdata;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!mem_wait) begin
                  mem_wren <= 1'b0;
                  mem_rden <= 1'b0;
                  r_rr_ptr <= ~r_winner;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // In-order tag FIFO: one bit per outstanding read naming its client.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_mem <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_winner;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Read return steering; rdata holds its last value between returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_rd_valid <= 1'b0;
         c1_rd_valid <= 1'b0;
         c0_rdata    <= '0;
         c1_rdata    <= '0;
         rd_err      <= 1'b0;
      end else begin
         c0_rd_valid <= w_pop & ~w_head;
         c1_rd_valid <= w_pop &  w_head;
         if (w_pop & ~w_head) c0_rdata <= mem_rdata;
         if (w_pop &  w_head) c1_rdata <= mem_rdata;
         if (mem_rd_valid & w_empty) rd_err <= 1'b1;
      end
   end

`ifdef SYN_SYS_MEM_ARB_STATS_EN
   // Saturating grant counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_grant_cnt <= '0;
         c1_grant_cnt <= '0;
      end else begin
         if (w_accept & ~r_winner & ~&c0_grant_cnt) c0_grant_cnt <= c0_grant_cnt + 1'b1;
         if (w_accept &  r_winner & ~&c1_grant_cnt) c1_grant_cnt <= c1_grant_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_syn_sys_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_syn_sys_mem_arb                                              |
// | Description: Self-checking bench for syn_sys_mem_arb. A transaction-level   |
// |              model (pending command, tag queue, return registers) predicts  |
// |              every output each cycle; directed scenarios pin the model with |
// |              literal expectations; a randomized phase follows.              |
// | Config     : SYN_SYS_MEM_ARB_STATS_EN also checks the grant counters        |
// | Revision   : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_syn_sys_mem_arb;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 27;
   localparam int DEPTH   = 8;
   localparam int STATS_W = 16;
   localparam int CNT_MAX = (1 << STATS_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] wren = '0, rden = '0;
   logic [1:0][ADDR_W-1:0] addr = '0;
   logic [1:0][DATA_W-1:0] wdata = '0;
   logic [1:0] cwait, rdv;
   logic [1:0][DATA_W-1:0] rdata;
   logic mem_wait = 1'b0, mem_rd_valid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic mem_wren, mem_rden, rd_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
`ifdef SYN_SYS_MEM_ARB_STATS_EN
   logic [1:0][STATS_W-1:0] gcnt;
`endif

   always #5 clk = ~clk;

   syn_sys_mem_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_FIFO_DEPTH(DEPTH), .STATS_W(STATS_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_wren(wren[0]), .c0_rden(rden[0]), .c0_addr(addr[0]), .c0_wdata(wdata[0]),
      .c0_wait(cwait[0]), .c0_rd_valid(rdv[0]), .c0_rdata(rdata[0]),
      .c1_wren(wren[1]), .c1_rden(rden[1]), .c1_addr(addr[1]), .c1_wdata(wdata[1]),
      .c1_wait(cwait[1]), .c1_rd_valid(rdv[1]), .c1_rdata(rdata[1]),
      .mem_wait(mem_wait), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
`ifdef SYN_SYS_MEM_ARB_STATS_EN
      .c0_grant_cnt(gcnt[0]), .c1_grant_cnt(gcnt[1]),
`endif
      .rd_err(rd_err)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                     m_busy;      // a command is presented to memory
   int                     m_cli;
   bit                     m_wr;
   logic [ADDR_W-1:0]      m_addr;
   logic [DATA_W-1:0]      m_wdata;
   int                     m_rr;
   int                     tagq[$];
   bit [1:0]               m_rdv;
   logic [1:0][DATA_W-1:0] m_rdata;
   bit                     m_err;
   int                     m_cnt[2];
   int                     m_acc_cli;   // client accepted in the last cycle, -1 none

   task automatic model_reset();
      m_busy = 0; m_cli = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_rr = 0;
      tagq.delete(); m_rdv = '0; m_rdata = '0; m_err = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_acc_cli = -1;
   endtask

   // Advance the model by one clock using this cycle's inputs.
   task automatic model_update();
      int sz, h, win;
      bit [1:0] elig;
      if (!rst_n) begin
         model_reset();
         return;
      end
      sz = tagq.size();
      m_acc_cli = -1;
      m_rdv = '0;
      if (mem_rd_valid) begin
         if (sz == 0) m_err = 1;
         else begin
            h = tagq.pop_front();
            m_rdv[h] = 1;
            m_rdata[h] = mem_rdata;
         end
      end
      if (m_busy && !mem_wait) begin
         if (!m_wr) tagq.push_back(m_cli);
         if (m_cnt[m_cli] < CNT_MAX) m_cnt[m_cli]++;
         m_acc_cli = m_cli;
         m_rr = 1 - m_cli;
         m_busy = 0;
      end else if (!m_busy) begin
         for (int c = 0; c < 2; c++) elig[c] = wren[c] || (rden[c] && sz < DEPTH);
         if (elig != 2'b00) begin
            win = elig[m_rr] ? m_rr : 1 - m_rr;
            m_busy = 1; m_cli = win; m_wr = wren[win];
            m_addr = addr[win]; m_wdata = wdata[win];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_wren", mem_wren, m_busy && m_wr);
         chk("mem_rden", mem_rden, m_busy && !m_wr);
         if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
         end
         for (int c = 0; c < 2; c++) begin
            chk("c_wait", cwait[c], !(m_busy && !mem_wait && m_cli == c));
            chk("c_rd_valid", rdv[c], m_rdv[c]);
            chk("c_rdata", rdata[c], m_rdata[c]);
`ifdef SYN_SYS_MEM_ARB_STATS_EN
            chk("grant_cnt", gcnt[c], m_cnt[c]);
`endif
         end
         chk("rd_err", rd_err, m_err);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset();
      rst_n = 0; mem_rd_valid = 0;
      model_reset();
      repeat (2) step();
      #1;
      chk("rst_c0_wait", cwait[0], 1);
      chk("rst_c1_wait", cwait[1], 1);
      chk("rst_mem_wren", mem_wren, 0);
      chk("rst_mem_rden", mem_rden, 0);
      chk("rst_rd_valid", rdv, 0);
      chk("rst_rd_err", rd_err, 0);
      rst_n = 1;
   endtask

   task automatic wait_accept(input int c, input int maxc, output bit ok);
      ok = 0;
      for (int k = 0; k < maxc; k++) begin
         #1;
         if (cwait[c] == 1'b0) begin
            ok = 1;
            step();
            return;
         end
         step();
      end
   endtask

   task automatic do_req(input int c, input bit w, input bit r, input int a, input logic [DATA_W-1:0] d);
      bit ok;
      wren[c] = w; rden[c] = r; addr[c] = ADDR_W'(a); wdata[c] = d;
      wait_accept(c, 40, ok);
      chk("req_accept", ok, 1);
      wren[c] = 0; rden[c] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   int  g[8];
   int  n;
   bit  ok;
   bit [1:0] act_req;
   int  k;

   initial begin
      model_reset();
      chk_en = 1;
      do_reset();

      // 1: single c0 write, no stall
      wren[0] = 1; addr[0] = 27'h10; wdata[0] = 32'hA5A5A5A5; mem_wait = 0;
      step();
      #1;
      chk("s1_mem_wren", mem_wren, 1);
      chk("s1_mem_addr", mem_addr, 27'h10);
      chk("s1_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("s1_c0_wait", cwait[0], 0);
      chk("s1_c1_wait", cwait[1], 1);
      step();
      wren[0] = 0;
      #1;
      chk("s1_mem_wren_clr", mem_wren, 0);

      // 2: continuous writes from both clients alternate
      do_reset();
      wren = 2'b11; n = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (cwait[0] == 1'b0) begin g[n] = 0; n++; end
         if (cwait[1] == 1'b0) begin g[n] = 1; n++; end
         step();
      end
      wren = 2'b00;
      chk("s2_grants", n, 4);
      chk("s2_g0", g[0], 0);
      chk("s2_g1", g[1], 1);
      chk("s2_g2", g[2], 0);
      chk("s2_g3", g[3], 1);
`ifdef SYN_SYS_MEM_ARB_STATS_EN
      #1;
      chk("s2_c0_cnt", gcnt[0], 2);
      chk("s2_c1_cnt", gcnt[1], 2);
`endif

      // 3: c1 read stalled for 5 cycles
      do_reset();
      rden[1] = 1; addr[1] = 27'h123; mem_wait = 1;
      step();
      for (int i = 1; i <= 6; i++) begin
         mem_wait = (i <= 5);
         #1;
         chk("s3_mem_rden", mem_rden, 1);
         chk("s3_mem_addr", mem_addr, 27'h123);
         chk("s3_c1_wait", cwait[1], (i == 6) ? 0 : 1);
         step();
      end
      rden[1] = 0; mem_wait = 0;

      // 4: reads from c0 then c1, returns in order
      do_reset();
      do_req(0, 0, 1, 32'h1, '0);
      do_req(1, 0, 1, 32'h2, '0);
      mem_rd_valid = 1; mem_rdata = 32'h11;
      step();
      mem_rd_valid = 0;
      #1;
      chk("s4_c0_rdv", rdv[0], 1);
      chk("s4_c0_rdata", rdata[0], 32'h11);
      chk("s4_c1_rdv0", rdv[1], 0);
      mem_rd_valid = 1; mem_rdata = 32'h22;
      step();
      mem_rd_valid = 0;
      #1;
      chk("s4_c1_rdv", rdv[1], 1);
      chk("s4_c1_rdata", rdata[1], 32'h22);
      chk("s4_c0_rdv1", rdv[0], 0);
      chk("s4_c0_hold", rdata[0], 32'h11);

      // 5: tag FIFO full blocks reads but not writes
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_req(1, 0, 1, 32'h200 + i, '0);
      rden[1] = 1; addr[1] = 27'h300;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("s5_c1_stall", cwait[1], 1);
         chk("s5_no_rden", mem_rden, 0);
         step();
      end
      do_req(0, 1, 0, 32'h40, 32'hCAFE0001);
      mem_rd_valid = 1; mem_rdata = 32'h77;
      step();
      mem_rd_valid = 0;
      #1;
      chk("s5_ret_c1", rdv[1], 1);
      wait_accept(1, 10, ok);
      chk("s5_reenabled", ok, 1);
      rden[1] = 0;

      // 6: spurious return sets sticky error
      do_reset();
      mem_rd_valid = 1; mem_rdata = 32'hDEAD;
      step();
      mem_rd_valid = 0;
      #1;
      chk("s6_rd_err", rd_err, 1);
      repeat (3) step();
      chk("s6_rd_err_sticky", rd_err, 1);
      do_reset();

      // randomized phase with one mid-run reset
      act_req = '0;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            rst_n = 0; mem_rd_valid = 0;
            model_reset();
            step(); step();
            rst_n = 1;
         end
         for (int c = 0; c < 2; c++) begin
            if (act_req[c] && m_acc_cli == c) begin
               wren[c] = 0; rden[c] = 0; act_req[c] = 0;
            end
            if (!act_req[c] && $urandom_range(2) == 0) begin
               k = $urandom_range(3);
               wren[c] = (k <= 1) || (k == 3);
               rden[c] = (k >= 2);
               addr[c] = ADDR_W'($urandom);
               wdata[c] = $urandom;
               act_req[c] = 1;
            end
         end
         mem_wait = ($urandom_range(2) == 0);
         mem_rd_valid = (tagq.size() > 0) &&
                        ($urandom_range(((i / 500) % 2 == 1) ? 7 : 1) == 0);
         mem_rdata = $urandom;
         step();
      end

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
